seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed 4-digit 7-segment driver that sits directly downstream of the step tracker.
//  It consumes the tracker's bcd3..bcd0 digit codes and its si flag.
//  It snapshots them once per scan frame so the display never tears, scans one digit per slot,
//  inserts an anti-ghosting blank window, and drives the shared anodes, segments and DP on the board.
// PARAMETERS
//  REFRESH_DIV   100000  sys_clk cycles per digit slot; must be >= 2
//  BLANK_CYCLES  2       cycles at start of each slot with all anodes off; must be < REFRESH_DIV
//  ACTIVE_LOW    1       1: an/seg/dp asserted low; 0: asserted high
//  LZ_BLANK      0       1: suppress leading zeros on digits 3..1; digit 0 is never suppressed
// PORTS
//  sys_clk  in   1   system clock; all logic on posedge
//  reset    in   1   asynchronous, active-high reset
//  bcd3     in   5   digit code for the leftmost digit
//  bcd2     in   5   digit code
//  bcd1     in   5   digit code
//  bcd0     in   5   digit code for the rightmost digit
//  si       in   1   saturation indicator; lights DP of digit 3
//  an       out  4   digit enables; an[i] drives digit i
//  seg      out  7   {g,f,e,d,c,b,a}
//  dp       out  1   decimal point
// BEHAVIOUR
//  State
//   - cnt: prescaler, 0..REFRESH_DIV-1. tick = (cnt == REFRESH_DIV-1). cnt wraps to 0 on tick.
//   - idx: 2-bit digit index. On tick, idx <= idx+1 mod 4. Scan order is 0,1,2,3,0...
//   - Shadow regs sh_bcd3..0 and sh_si are loaded from the inputs on the tick where idx==3,
//     i.e. the cycle idx wraps to 0. They hold between loads. Input changes mid-frame are
//     invisible until the next wrap.
//  Reset (asynchronous, active-high)
//   - cnt=0, idx=0, shadows=0.
//   - an, seg and dp all inactive: with ACTIVE_LOW=1, an=4'hF, seg=7'h7F, dp=1.
//   - Reset asserted mid-slot blanks the outputs immediately (asynchronously).
//   - After release, slot 0 starts with cnt=0. The first frame shows the zeroed shadows
//     (digit 0 shows "0"; with LZ_BLANK=1, digits 3..1 are blank).
//  Outputs (all registered; 1-cycle latency from cnt/idx to the pins)
//   - Blank window, cnt < BLANK_CYCLES: an all inactive.
//   - Otherwise: only an[idx] is active.
//   - seg and dp always reflect the current idx, including during the blank window.
//  Decode, active-high form {g..a}, inverted when ACTIVE_LOW=1
//   - 0=0111111  1=0000110  2=1011011  3=1001111  4=1100110
//   - 5=1101101  6=1111101  7=0000111  8=1111111  9=1101111
//   - 31 (5'h1F) = underscore, 0001000
//   - 10..30 = blank, 0000000
//  Leading-zero suppression (LZ_BLANK=1)
//   - digit k (k=3..1) is blank iff every shadow digit j >= k equals 0.
//   - Code 31 counts as non-zero.
//  DP: active only when idx==3, sh_si==1, and outside the blank window.
//  Width rules
//   - cnt is $clog2(REFRESH_DIV) bits.
//   - Comparisons are unsigned; no arithmetic on digit codes.
// TESTING  (REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1 unless noted)
//  1. Reset for 3 cycles, then reset again 2 cycles into slot 1
//     -> an=F, seg=7F, dp=1 while reset is high; cnt=0 and idx=0 after release.
//  2. bcd3..0 = 0,8,31,5, si=0, held for 2 frames; second frame
//     -> slot0: an=E seg=12; slot1: an=D seg=77; slot2: an=B seg=00; slot3: an=7 seg=40.
//  3. Same as 2, then change bcd0 to 7 during slot 1
//     -> slot0 of that frame stays seg=12; the next frame's slot0 shows seg=78.
//  4. Each slot, observe the cycle after cnt=0
//     -> an=F for exactly 1 cycle, then the single active anode for 3 cycles.
//  5. si=1
//     -> dp=0 only during active cycles of slot 3; dp=1 in slots 0..2 and in all blank windows.
//  6. LZ_BLANK=1, bcd3..0 = 0,0,4,2
//     -> slots 3,2: seg=7F; slot1: seg=19; slot0: seg=24.
//     Then bcd3..0 = 0,0,0,0 -> slot 0 still shows seg=40.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: snapshots digit codes once per frame,
// scans one digit per slot with a leading blank window, and drives registered pins.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          LZ_BLANK     = 1'b0
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [4:0] bcd3,
  input  logic [4:0] bcd2,
  input  logic [4:0] bcd1,
  input  logic [4:0] bcd0,
  input  logic       si,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned   CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            tick;
  logic [3:0][4:0] sh_bcd;
  logic            sh_si;

  logic [3:0]      zero_above;
  logic            blank_win;
  logic            suppress;
  logic [3:0]      an_hi;
  logic [6:0]      seg_hi;
  logic            dp_hi;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'b0111111;
      5'd1:    s = 7'b0000110;
      5'd2:    s = 7'b1011011;
      5'd3:    s = 7'b1001111;
      5'd4:    s = 7'b1100110;
      5'd5:    s = 7'b1101101;
      5'd6:    s = 7'b1111101;
      5'd7:    s = 7'b0000111;
      5'd8:    s = 7'b1111111;
      5'd9:    s = 7'b1101111;
      5'd31:   s = 7'b0001000;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNT_MAX);

  // Shadows load on the frame-wrapping tick so a whole frame shows one coherent snapshot.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      sh_bcd <= '0;
      sh_si  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          sh_bcd <= {bcd3, bcd2, bcd1, bcd0};
          sh_si  <= si;
        end
      end
    end
  end

  always_comb begin
    zero_above    = '0;
    zero_above[3] = (sh_bcd[3] == 5'd0);
    zero_above[2] = zero_above[3] && (sh_bcd[2] == 5'd0);
    zero_above[1] = zero_above[2] && (sh_bcd[1] == 5'd0);
    zero_above[0] = 1'b0;

    blank_win = (cnt < BLANK_END);
    suppress  = LZ_BLANK && zero_above[idx];

    seg_hi = suppress ? 7'b0000000 : decode(sh_bcd[idx]);
    an_hi  = blank_win ? 4'b0000 : (4'b0001 << idx);
    dp_hi  = !blank_win && (idx == 2'd3) && sh_si;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= an_hi  ^ {4{ACTIVE_LOW}};
      seg <= seg_hi ^ {7{ACTIVE_LOW}};
      dp  <= dp_hi  ^ ACTIVE_LOW;
    end
  end

endmodule
